// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display paths: FSM encoding,
// dark-output constants and the active-low hex segment table.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment cathode pattern.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode display scanner. The slow scan clock is sampled
// as data, turned into a one-cycle tick, and each tick advances the digit
// after a dead-time blanking interval. Digit data is latched once per frame.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_slow,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] sh_digit_q, sh_digit_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic [3:0]  sh_blank_q, sh_blank_d;
  logic        capture;
  logic        fd_d;
  logic [3:0]  an_d;
  logic [6:0]  seg_d, dec_seg;
  logic        dp_d;

  // Synchronise clk_slow and register a one-cycle pulse on each rising edge.
  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_slow};
      edge_q <= sync_q[SYNC_STAGES-1];
      tick   <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  // Next state: enable wins, then tick (advance + restart blank), then blank countdown.
  // NOTE: every variable gets its default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fd_d    = 1'b0;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = 2'd0;
      cnt_d   = 8'd0;
    end else if (tick) begin
      state_d = ST_BLANK;
      cnt_d   = CNT_LOAD;
      if (state_q == ST_OFF) begin
        idx_d   = 2'd0;
        capture = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          capture = 1'b1;
          fd_d    = 1'b1;
        end
      end
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == 8'd0) state_d = ST_ON;
      else               cnt_d   = cnt_q - 8'd1;
    end
  end

  assign sh_digit_d = capture ? digits   : sh_digit_q;
  assign sh_dp_d    = capture ? dp_in    : sh_dp_q;
  assign sh_blank_d = capture ? blank_in : sh_blank_q;

  hex_to_seg7 u_hex_to_seg7 (
    .hex (sh_digit_d[{idx_d, 2'b00} +: 4]),
    .seg (dec_seg)
  );

  // Output values for the coming cycle, derived from the next state so the
  // registered pins line up with the FSM without an extra cycle of lag.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == ST_ON) begin
      an_d  = sh_blank_d[idx_d] ? AN_OFF : ~(4'b0001 << idx_d);
      seg_d = dec_seg;
      dp_d  = ~sh_dp_d[idx_d];
    end
  end

  // FSM, counter, frame shadow and output registers; reset forces the display dark.
  // NOTE: the shadow registers are only a handful of flops, so they are reset
  // with everything else; a real memory array would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      idx_q      <= 2'd0;
      cnt_q      <= 8'd0;
      sh_digit_q <= 16'd0;
      sh_dp_q    <= 4'd0;
      sh_blank_q <= 4'd0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sh_digit_q <= sh_digit_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a behavioural model tracks which
// digit should be lit from tick timing and per-frame snapshots; a compare
// process checks every cycle, and directed literal checks pin the model.
module tb_seg_scan_driver;

  localparam int BLANK = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_slow = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int fd_seen = 0;
  bit cmp_en = 1'b0;

  seg_scan_driver #(.BLANK_CYCLES(BLANK), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_slow   (clk_slow),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lit segments (active-high {g..a}) of a standard hex display, inverted for the pins.
  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    logic [6:0] lit;
    case (h)
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  // ---------------- behavioural model ----------------
  // hist[n] = clk_slow as sampled n+1 edges ago; a scan rise acts on the FSM
  // four edges after it is first sampled.
  logic [3:0]  hist;
  bit          m_active;
  int          m_pos;
  int          m_since;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_blank;
  bit          m_fd;
  wire         m_tick = hist[2] & ~hist[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0; m_active <= 0; m_pos <= 0; m_since <= 0;
      m_dig <= '0; m_dp <= '0; m_blank <= '0; m_fd <= 0;
    end else begin
      hist <= {hist[2:0], clk_slow};
      m_fd <= 0;
      if (!en) begin
        m_active <= 0;
        m_pos    <= 0;
      end else if (m_tick) begin
        m_since <= 0;
        if (!m_active || m_pos == 3) begin
          m_dig <= digits; m_dp <= dp_in; m_blank <= blank_in;
        end
        if (!m_active) begin
          m_active <= 1;
          m_pos    <= 0;
        end else begin
          m_pos <= (m_pos + 1) % 4;
          if (m_pos == 3) m_fd <= 1;
        end
      end else if (m_since < 100000) begin
        m_since <= m_since + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (frame_done === 1'b1) fd_seen++;
    if (cmp_en) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (m_active && m_since >= BLANK) begin
        e_an  = m_blank[m_pos] ? 4'hF : ~(4'b0001 << m_pos);
        e_seg = ref_seg(m_dig[m_pos*4 +: 4]);
        e_dp  = ~m_dp[m_pos];
      end
      check("model_an", an, e_an);
      check("model_seg", seg, e_seg);
      check("model_dp", dp, e_dp);
      check("model_frame_done", frame_done, m_fd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic scan_pulse(input int high, input int low);
    @(negedge clk);
    clk_slow = 1'b1;
    repeat (high) @(negedge clk);
    clk_slow = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic check_show(input string tag, input logic [3:0] ea, input logic [6:0] es);
    check({tag, "_an"}, an, ea);
    check({tag, "_seg"}, seg, es);
  endtask

  logic [3:0] rot_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [6:0] rot_seg [4] = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};

  initial begin
    int lat;
    int fd_before;
    int r;

    // Reset state
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_dark_an", an, 4'hF);

    // Latency: tick at +3, 64 blank cycles, first lit on the 68th edge
    en = 1'b1;
    digits = 16'h1234;
    fd_seen = 0;
    @(negedge clk);
    clk_slow = 1'b1;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (an !== 4'hF) break;
    end
    check("latency_edges", lat, 68);
    @(negedge clk);
    clk_slow = 1'b0;
    check_show("first_digit", 4'b1110, 7'b0011001);
    check("first_dp", dp, 1'b1);
    repeat (20) @(negedge clk);

    // Rotation through all four digits and the wrap
    for (int k = 0; k < 4; k++) begin
      scan_pulse(5, 75);
      check_show($sformatf("rot%0d", k), rot_an[k], rot_seg[k]);
      if (k == 2) check("no_fd_before_wrap", fd_seen, 0);
    end
    check("fd_once_after_wrap", fd_seen, 1);

    // Frame coherency: mid-frame digit change invisible until the wrap
    scan_pulse(5, 75);
    scan_pulse(5, 75);
    digits = 16'h8888;
    repeat (3) @(negedge clk);
    check_show("coh_idx2_old", 4'b1011, 7'b0100100);
    scan_pulse(5, 75);
    check_show("coh_idx3_old", 4'b0111, 7'b1111001);
    scan_pulse(5, 75);
    check_show("coh_idx0_new", 4'b1110, 7'b0000000);
    scan_pulse(5, 75);
    check_show("coh_idx1_new", 4'b1101, 7'b0000000);

    // Blank and decimal-point masks, taking effect at the next frame
    blank_in = 4'b0100;
    dp_in = 4'b0001;
    scan_pulse(5, 75);
    check("mask_old_idx2_an", an, 4'b1011);
    scan_pulse(5, 75);
    scan_pulse(5, 75);
    check("mask_idx0_an", an, 4'b1110);
    check("mask_idx0_dp", dp, 1'b0);
    scan_pulse(5, 75);
    check("mask_idx1_dp", dp, 1'b1);
    scan_pulse(5, 75);
    check("mask_idx2_an", an, 4'hF);
    check("mask_idx2_dp", dp, 1'b1);
    scan_pulse(5, 75);
    check("mask_idx3_an", an, 4'b0111);

    // en=0 in the tick cycle at idx 3: goes dark, no frame_done
    fd_before = fd_seen;
    @(negedge clk);
    clk_slow = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("coll_an", an, 4'hF);
    check("coll_frame_done", frame_done, 1'b0);
    clk_slow = 1'b0;
    repeat (50) @(negedge clk);
    check("coll_no_fd", fd_seen, fd_before);

    // Re-enable: OFF->BLANK captures fresh inputs, starts at digit 0, no frame_done
    en = 1'b1;
    digits = 16'hA5C3;
    scan_pulse(5, 75);
    check_show("reen_idx0", 4'b1110, 7'b0110000);
    check("reen_dp", dp, 1'b0);
    check("reen_no_fd", fd_seen, fd_before);

    // Tick during BLANK restarts the interval with the advanced index
    scan_pulse(5, 75);
    scan_pulse(5, 75);
    blank_in = 4'b0000;
    dp_in = 4'b0000;
    fd_before = fd_seen;
    scan_pulse(5, 25);
    scan_pulse(5, 55);
    check("restart_still_dark", an, 4'hF);
    repeat (10) @(negedge clk);
    check_show("restart_idx0", 4'b1110, 7'b0110000);
    check("restart_dp", dp, 1'b1);
    check("restart_fd", fd_seen, fd_before + 1);

    // Async reset while lit: dark in the same timestep
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dp", dp, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_dark", an, 4'hF);

    // Randomised scan timing, enables, data and occasional resets
    for (int n = 0; n < 70; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      en = 1'b0;
      else if (r < 35) en = 1'b1;
      if (r % 5 == 0)  digits = 16'($urandom);
      if (r % 7 == 0)  dp_in = 4'($urandom);
      if (r % 11 == 0) blank_in = 4'($urandom);
      if (r >= 96) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rand_rst_an", an, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
      end
      scan_pulse(int'($urandom_range(1, 10)), int'($urandom_range(1, 110)));
    end

    repeat (80) @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
